// File: rtl/clock_pkg.sv
// Shared definitions for the MM:SS clock blocks: digit limits, widths and the
// countdown state encoding.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } cd_state_t;

    localparam int unsigned SEC_1_MAX  = 9;
    localparam int unsigned SEC_10_MAX = 5;
    localparam int unsigned MIN_1_MAX  = 9;
    localparam int unsigned MIN_10_MAX = 5;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned SEC_10_W = 3;

    function automatic logic digits_valid(input logic [DIGIT_W-1:0]  min_10,
                                          input logic [DIGIT_W-1:0]  min_1,
                                          input logic [SEC_10_W-1:0] sec_10,
                                          input logic [DIGIT_W-1:0]  sec_1);
        return (min_10 <= DIGIT_W'(MIN_10_MAX)) && (min_1 <= DIGIT_W'(MIN_1_MAX)) &&
               (sec_10 <= SEC_10_W'(SEC_10_MAX)) && (sec_1 <= DIGIT_W'(SEC_1_MAX));
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One down-counting digit with parallel load; wraps 0 -> MAX and raises a
// combinational borrow so digits can be chained.
module bcd_down_digit
    import clock_pkg::*;
#(
    parameter int unsigned MAX   = 9,
    parameter int unsigned WIDTH = DIGIT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec_en,
    output logic [WIDTH-1:0] digit,
    output logic             borrow_out
);

    logic [WIDTH-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (dec_en) begin
            digit_d = (digit_q == '0) ? WIDTH'(MAX) : digit_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = dec_en && (digit_q == '0);

endmodule

// File: rtl/countdown_mmss.sv
// MM:SS countdown timer: load validation and run/pause/done control around a
// chain of four borrowing BCD digits.
module countdown_mmss
    import clock_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                load,
    input  logic [DIGIT_W-1:0]  load_min_10,
    input  logic [DIGIT_W-1:0]  load_min_1,
    input  logic [SEC_10_W-1:0] load_sec_10,
    input  logic [DIGIT_W-1:0]  load_sec_1,
    input  logic                start,
    input  logic                pause,
    output logic [DIGIT_W-1:0]  minutes_10,
    output logic [DIGIT_W-1:0]  minutes_1,
    output logic [SEC_10_W-1:0] sec_10,
    output logic [DIGIT_W-1:0]  sec_1,
    output logic                running,
    output logic                done,
    output logic                load_err
);

    cd_state_t state_q, state_d;
    logic      running_q, running_d;
    logic      done_q, done_d;
    logic      load_err_q, load_err_d;
    logic      load_ok, dec_go;
    logic      value_zero, value_one;
    logic      sec_1_borrow, sec_10_borrow, min_1_borrow, unused_borrow;

    assign value_zero = (minutes_10 == '0) && (minutes_1 == '0) && (sec_10 == '0) &&
                        (sec_1 == '0);
    assign value_one  = (minutes_10 == '0) && (minutes_1 == '0) && (sec_10 == '0) &&
                        (sec_1 == DIGIT_W'(1));

    // A cycle carrying load never also acts on pause/start/tick, even if rejected.
    always_comb begin
        state_d    = state_q;
        load_ok    = 1'b0;
        dec_go     = 1'b0;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (digits_valid(load_min_10, load_min_1, load_sec_10, load_sec_1)) begin
                load_ok = 1'b1;
                state_d = IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (pause) begin
            if (state_q == RUN) state_d = PAUSED;
        end else if (start) begin
            if ((state_q == IDLE || state_q == PAUSED) && !value_zero) state_d = RUN;
        end else if (tick && state_q == RUN) begin
            dec_go = 1'b1;
            if (value_one) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign running  = running_q;
    assign done     = done_q;
    assign load_err = load_err_q;

    bcd_down_digit #(.MAX(SEC_1_MAX), .WIDTH(DIGIT_W)) u_sec_1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_ok),
        .load_val   (load_sec_1),
        .dec_en     (dec_go),
        .digit      (sec_1),
        .borrow_out (sec_1_borrow)
    );

    bcd_down_digit #(.MAX(SEC_10_MAX), .WIDTH(SEC_10_W)) u_sec_10 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_ok),
        .load_val   (load_sec_10),
        .dec_en     (sec_1_borrow),
        .digit      (sec_10),
        .borrow_out (sec_10_borrow)
    );

    bcd_down_digit #(.MAX(MIN_1_MAX), .WIDTH(DIGIT_W)) u_min_1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_ok),
        .load_val   (load_min_1),
        .dec_en     (sec_10_borrow),
        .digit      (minutes_1),
        .borrow_out (min_1_borrow)
    );

    // Never borrows: RUN is only entered with a nonzero value and leaves at 00:00.
    bcd_down_digit #(.MAX(MIN_10_MAX), .WIDTH(DIGIT_W)) u_min_10 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_ok),
        .load_val   (load_min_10),
        .dec_en     (min_1_borrow),
        .digit      (minutes_10),
        .borrow_out (unused_borrow)
    );

endmodule

// File: doc/countdown_mmss.md
# countdown_mmss

Four-digit BCD countdown timer (MM:SS, 59:59 down to 00:00) that counts in the opposite direction to the clock's seconds/minutes chain. Loaded with a start time, it decrements one second per `tick` through a borrow chain and raises a one-cycle `done` pulse on reaching 00:00. It sits beside the up-counting minute/second blocks, shares their digit widths and limits, and drives the same display path.

## Interface
Parameters:
- none (digit limits are fixed package constants)

Ports:
- `clk` in 1: system clock; all state changes on rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `tick` in 1: one-second enable, one `clk` wide.
- `load` in 1: load `load_*` digits into the counter.
- `load_min_10` in 4: minutes tens, BCD, valid 0..5.
- `load_min_1` in 4: minutes units, BCD, valid 0..9.
- `load_sec_10` in 3: seconds tens, valid 0..5.
- `load_sec_1` in 4: seconds units, BCD, valid 0..9.
- `start` in 1: begin or resume counting.
- `pause` in 1: suspend counting.
- `minutes_10` out 4: current minutes tens.
- `minutes_1` out 4: current minutes units.
- `sec_10` out 3: current seconds tens.
- `sec_1` out 4: current seconds units.
- `running` out 1: high in RUN.
- `done` out 1: one-cycle pulse on reaching 00:00.
- `load_err` out 1: one-cycle pulse on rejected load.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Priority per cycle: `rst_n` low > `load` > `pause` > `start` > `tick`.
- Reset: state IDLE, all digits 0, `running`=0, `done`=0, `load_err`=0.
- `load` in any state: if every digit is in range, copy digits and go to IDLE. Otherwise leave digits and state unchanged and pulse `load_err`.
- `start`: IDLE or PAUSED with a nonzero value goes to RUN. With value 00:00 it is ignored (no `done`). In RUN or DONE it is ignored.
- `pause`: RUN goes to PAUSED. Ignored in other states.
- `tick` in RUN decrements the value by one second:
  - `sec_1` 0 wraps to 9 and borrows into `sec_10`.
  - `sec_10` 0 wraps to 5 and borrows into `minutes_1`.
  - `minutes_1` 0 wraps to 9 and borrows into `minutes_10`.
- Decrement from 00:01 to 00:00: go to DONE and pulse `done` in the same update.
- DONE holds 00:00. Only `load` or reset leaves DONE.
- `tick` outside RUN is ignored.
- `tick` in the same cycle as `start` does not decrement; counting begins on the next `tick`.
- `tick` in the same cycle as `pause` does not decrement.
- Digits never hold out-of-range values.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- Load: digits visible one cycle after the `load` edge.
- Decrement: new value visible one cycle after the `tick` edge.
- `done` and `load_err` are high for exactly one cycle, coincident with the value/state update that causes them.
- `running` changes in the cycle after `start`/`pause` is sampled.
- Reset mid-count clears everything on the next edge. A pending `tick` in that cycle is discarded.
- 00:00 is reached exactly N ticks after `start`, where N is the loaded value in seconds.

## Structure
- Shared package `clock_pkg`:
  - state enum `cd_state_t` {IDLE, RUN, PAUSED, DONE};
  - constants `SEC_1_MAX`=9, `SEC_10_MAX`=5, `MIN_1_MAX`=9, `MIN_10_MAX`=5;
  - digit width constants 4/3.
- One sub-module `bcd_down_digit`:
  - parameters MAX and width;
  - inputs `clk`, `rst_n`, `load`, `load_val`, `dec_en`;
  - outputs `digit`, `borrow_out` (combinational: high when `dec_en` is high and digit is 0).
- Instantiate it four times, chaining `borrow_out` to the next digit's `dec_en`. The top holds the FSM and load validation.

## Test plan
- Reset, then load 01:05, then `start`, then 65 ticks: value steps 01:05 → 01:04 … 00:59 → 00:00, `done` pulses once on tick 65, state DONE.
- Load 10:00, then start, then one tick: value 09:59, all three borrows in one cycle, `running`=1.
- Load 00:03, start, tick, pause, three ticks, start, two ticks: value 00:02 during pause, reaches 00:00 with `done` only after the final tick.
- Load with `load_sec_10`=6, and separately `load_min_1`=10: `load_err` pulses, digits unchanged. Load 00:00 then start: stays IDLE, no `done`.
- Assert `tick` together with `start`, and `tick` together with `pause`: no decrement in either cycle.
- Drive `rst_n` low mid-count at 00:30 while `tick` is high: next edge gives 00:00, IDLE, `running`=0, no `done`.
